// File: rtl/baud_frac_tick_if.sv
// Control and tick bundle for baud_frac_tick: divisor programming, restart
// and enable go in; the registered ticks and divisor status come out.
interface baud_frac_tick_if #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8,
  parameter int IDX_W  = 4
);
  logic              Enable;
  logic              Restart;
  logic              DivLoad;
  logic [INT_W-1:0]  DivInt;
  logic [FRAC_W-1:0] DivFrac;
  logic              SampleTick;
  logic              BitTick;
  logic [IDX_W-1:0]  SampleIdx;
  logic              DivPending;
  logic              DivAck;

  modport master (
    output Enable, Restart, DivLoad, DivInt, DivFrac,
    input  SampleTick, BitTick, SampleIdx, DivPending, DivAck
  );

  modport slave (
    input  Enable, Restart, DivLoad, DivInt, DivFrac,
    output SampleTick, BitTick, SampleIdx, DivPending, DivAck
  );
endinterface

// File: rtl/baud_frac_tick.sv
// Fractional baud tick generator: integer + binary-fraction divisor with an
// error-spreading accumulator, shadowed divisor updates and start-bit re-phasing.
module baud_frac_tick #(
  parameter int INT_W        = 16,
  parameter int FRAC_W       = 8,
  parameter int OVERSAMPLE   = 16,
  parameter int BIT_PHASE    = OVERSAMPLE - 1,
  parameter int DEFAULT_INT  = 162,
  parameter int DEFAULT_FRAC = 195
) (
  input  logic            F25Clk,
  input  logic            reset,
  baud_frac_tick_if.slave bus
);
  localparam int IDX_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [INT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [INT_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [INT_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pending_q, pending_d;
  logic              sample_tick_q, sample_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              ack_q, ack_d;

  logic [INT_W-1:0]  ie;
  logic [INT_W:0]    last_cnt;
  logic              terminal;
  logic [FRAC_W:0]   acc_sum;
  logic [IDX_W-1:0]  idx_next;

  // Integer divisors below 2 are clamped so a period is never shorter than 2 cycles.
  assign ie       = (act_int_q < INT_W'(2)) ? INT_W'(2) : act_int_q;
  assign last_cnt = {1'b0, ie} + {{INT_W{1'b0}}, extra_q} - {{INT_W{1'b0}}, 1'b1};
  assign terminal = ({1'b0, cnt_q} == last_cnt);
  assign acc_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
  assign idx_next = (idx_q == IDX_W'(OVERSAMPLE - 1)) ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    extra_d       = extra_q;
    idx_d         = idx_q;
    act_int_d     = act_int_q;
    act_frac_d    = act_frac_q;
    sh_int_d      = sh_int_q;
    sh_frac_d     = sh_frac_q;
    pending_d     = pending_q;
    sample_tick_d = 1'b0;
    bit_tick_d    = 1'b0;
    ack_d         = 1'b0;

    if (bus.DivLoad) begin
      sh_int_d  = bus.DivInt;
      sh_frac_d = bus.DivFrac;
      pending_d = 1'b1;
    end

    // Restart wins over a coincident terminal count and swallows its tick.
    if (bus.Restart) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      idx_d   = '0;
      if (bus.DivLoad) begin
        act_int_d  = bus.DivInt;
        act_frac_d = bus.DivFrac;
        pending_d  = 1'b0;
        ack_d      = 1'b1;
      end else if (pending_q) begin
        act_int_d  = sh_int_q;
        act_frac_d = sh_frac_q;
        pending_d  = 1'b0;
        ack_d      = 1'b1;
      end
    end else if (bus.Enable) begin
      if (terminal) begin
        cnt_d            = '0;
        {extra_d, acc_d} = acc_sum;
        idx_d            = idx_next;
        sample_tick_d    = 1'b1;
        bit_tick_d       = (idx_q == IDX_W'(BIT_PHASE));
        // A load landing on this boundary stays pending; the older shadow applies now.
        if (pending_q) begin
          act_int_d  = sh_int_q;
          act_frac_d = sh_frac_q;
          acc_d      = '0;
          extra_d    = 1'b0;
          ack_d      = 1'b1;
          pending_d  = bus.DivLoad;
        end
      end else begin
        cnt_d = cnt_q + INT_W'(1);
      end
    end
  end

  always_ff @(posedge F25Clk) begin
    if (reset) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      extra_q       <= 1'b0;
      idx_q         <= '0;
      act_int_q     <= INT_W'(DEFAULT_INT);
      act_frac_q    <= FRAC_W'(DEFAULT_FRAC);
      sh_int_q      <= INT_W'(DEFAULT_INT);
      sh_frac_q     <= FRAC_W'(DEFAULT_FRAC);
      pending_q     <= 1'b0;
      sample_tick_q <= 1'b0;
      bit_tick_q    <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      extra_q       <= extra_d;
      idx_q         <= idx_d;
      act_int_q     <= act_int_d;
      act_frac_q    <= act_frac_d;
      sh_int_q      <= sh_int_d;
      sh_frac_q     <= sh_frac_d;
      pending_q     <= pending_d;
      sample_tick_q <= sample_tick_d;
      bit_tick_q    <= bit_tick_d;
      ack_q         <= ack_d;
    end
  end

  assign bus.SampleTick = sample_tick_q;
  assign bus.BitTick    = bit_tick_q;
  assign bus.SampleIdx  = idx_q;
  assign bus.DivPending = pending_q;
  assign bus.DivAck     = ack_q;
endmodule

// File: doc/baud_frac_tick.md
# baud_frac_tick

Parametrised fractional baud-tick generator for the UART transmit and receive datapaths. It produces a single-cycle oversample tick and a bit tick from the system clock. The divisor is runtime-programmable with an integer part and a binary fractional part, and error is spread by a fractional accumulator. Divisor changes are shadowed and applied only on a sample boundary. A restart input re-phases the generator to an incoming start bit.

## Interface
- INT_W, 16: width of integer divisor.
- FRAC_W, 8: width of fractional divisor (units of 1/2^FRAC_W cycle).
- OVERSAMPLE, 16: sample ticks per bit (>=1).
- BIT_PHASE, OVERSAMPLE-1: sample index on which BitTick fires (OVERSAMPLE/2-1 for RX mid-bit).
- DEFAULT_INT, 162 / DEFAULT_FRAC, 195: divisor after reset (9600 bps x16 at 25 MHz).
- F25Clk  in  1  system clock; one clock domain only.
- reset  in  1  synchronous, active-high reset.
- Enable  in  1  counting enable; low freezes all state.
- Restart  in  1  re-phase strobe.
- DivLoad  in  1  divisor write strobe.
- DivInt  in  INT_W  integer divisor, sampled on DivLoad.
- DivFrac  in  FRAC_W  fractional divisor, sampled on DivLoad.
- SampleTick  out  1  one-cycle oversample tick.
- BitTick  out  1  one-cycle bit tick, always coincident with a SampleTick.
- SampleIdx  out  clog2(OVERSAMPLE) (min 1)  completed-sample index, modulo OVERSAMPLE.
- DivPending  out  1  shadow divisor waiting to be applied.
- DivAck  out  1  one-cycle pulse when a divisor becomes active.

## Operation
- Active divisor (I, F); effective integer Ie = max(I, 2). Values below 2 are clamped.
- Period register L = Ie + extra, where extra is 0 or 1.
- Cycle counter cnt runs 0..L-1. Terminal count occurs when cnt == L-1.
- At terminal count:
  - cnt <= 0.
  - {c, acc} = acc + F, computed with FRAC_W+1 bits; acc <= sum low bits; extra <= c.
  - SampleIdx increments, wrapping OVERSAMPLE-1 -> 0.
- Average period is Ie + F/2^FRAC_W cycles. Long-run drift is zero.
- BitTick fires with the SampleTick whose pre-increment SampleIdx == BIT_PHASE.
- DivLoad latches DivInt/DivFrac into a shadow register and sets DivPending. A later DivLoad before application overwrites the shadow; the latest write wins.
- Shadow application happens at the next terminal count, or immediately on Restart:
  - active <= shadow, DivPending <= 0, DivAck pulses.
  - acc and extra are cleared.
  - The period starting after the boundary uses the new divisor.
- Restart, when sampled high:
  - cnt, acc, extra, SampleIdx <= 0. Any pending divisor is applied.
  - No SampleTick is produced for that cycle, even if it is a terminal count.
- DivLoad and Restart in the same cycle: the newly written value is applied immediately, and DivAck pulses.
- DivLoad coinciding with terminal count: the new value goes to shadow and is applied at the following boundary. The previous shadow, if any, is applied now.
- Enable low: cnt, acc, extra and SampleIdx hold, and no ticks are produced. DivLoad still latches. Restart still works.
- reset: active divisor = (DEFAULT_INT, DEFAULT_FRAC). Shadow takes the same values. All counters are 0.

## Timing
- Reset values: SampleTick=0, BitTick=0, SampleIdx=0, DivPending=0, DivAck=0.
- All outputs are registered. There is no combinational path from input to output.
- Tick timing:
  - The first SampleTick is high L cycles after the first edge with reset=0 and Enable=1.
  - Ticks repeat every L cycles, with L recomputed each period.
  - A SampleTick is registered: it is high in the cycle after cnt==L-1 is evaluated.
- After Restart sampled at edge k, the next SampleTick is at edge k+L.
- DivAck is high one cycle after the application edge, aligned with SampleTick at a boundary. DivPending falls on the same edge.
- Reset mid-period: the next edge yields the reset state. No tick is issued and the partial period is discarded.

## Test plan
- Defaults with OVERSAMPLE=16, no loads, Enable=1:
  - SampleTick periods are 162 or 163 cycles, with 195 of every 256 periods being 163.
  - BitTick occurs every 16th SampleTick, with SampleIdx 15->0.
- Load DivInt=10, DivFrac=128:
  - After DivAck, periods are 10, 10, 11, 10, 11, and so on.
  - DivPending is 1 from the load until the boundary.
- Load DivInt=0 and DivInt=1: each period is exactly 2 cycles, and no tick is ever missed.
- Restart at cnt=50 of a 162 period: no tick at the old terminal count, the next SampleTick is 162 cycles later, and SampleIdx=0.
- Restart together with DivLoad(20,0):
  - DivAck on the next cycle.
  - SampleTick 20 cycles after the Restart edge, then every 20 cycles.
- Enable low for 37 cycles mid-period delays the next tick by exactly 37 cycles. Reset asserted mid-period restores all outputs and the default divisor within 1 cycle.
